mips_regfile_scoreboard: RTL and testbench

//  Parametrised MIPS general-purpose register file with integrated pending-write scoreboard.

---
 rtl/mips_regfile_scoreboard.sv | 94 +++++++++
 tb/tb_mips_regfile_scoreboard.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_scoreboard.sv
// MIPS general-purpose register file with a per-register pending-write scoreboard.
// Combinational reads with optional writeback forwarding; r0 hardwired to zero.
module mips_regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned PEND_MAX = 3,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = $clog2(NUM_REGS),
    localparam int unsigned CW      = $clog2(PEND_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic                     iss_ready,
    output logic                     stall,
    output logic                     wb_err
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CW-1:0]     cnt_q  [NUM_REGS];
    logic [CW-1:0]     cnt_d  [NUM_REGS];
    logic              wb_err_q;

    logic wb_nz, wb_cnt_zero, wb_dec, iss_acc;

    assign wb_nz       = wb_en && (wb_addr != '0);
    assign wb_cnt_zero = (cnt_q[wb_addr] == '0);
    assign wb_dec      = wb_nz && !wb_cnt_zero;

    // A retiring writeback frees a slot for an issue to the same register this cycle.
    assign iss_ready = (cnt_q[iss_addr] != CW'(PEND_MAX)) || (wb_dec && (wb_addr == iss_addr));
    assign iss_acc   = iss_en && iss_ready && (iss_addr != '0);

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            logic inc, dec;
            inc      = iss_acc && (iss_addr == AW'(r));
            dec      = wb_dec && (wb_addr == AW'(r));
            cnt_d[r] = cnt_q[r];
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CW'(1);
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            if (wb_nz) begin
                regs_q[wb_addr] <= wb_data;
            end
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            // Writeback with nothing outstanding: keep the data, flag the bookkeeping slip.
            if (wb_nz && wb_cnt_zero) begin
                wb_err_q <= 1'b1;
            end
        end
    end

    assign wb_err = wb_err_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit, fwd;

        assign a   = rd_addr[i*AW +: AW];
        assign hit = (BYPASS != 0) && wb_en && (wb_addr == a);
        // Forwarding only clears the hazard when this writeback is the last one pending.
        assign fwd = hit && (cnt_q[a] == CW'(1));

        assign rd_data[i*DATA_W +: DATA_W] = (a == '0) ? '0 : (hit ? wb_data : regs_q[a]);
        assign rd_busy[i]                  = (cnt_q[a] != '0) && !fwd;
    end

    assign stall = |rd_busy;

endmodule

// File: tb/tb_mips_regfile_scoreboard.sv
// Bench for mips_regfile_scoreboard: directed scenarios plus random traffic, with and
// without forwarding, against an array-based model of registers and pending counts.
module tb_mips_regfile_scoreboard;

    localparam int AW = 5;
    localparam int PEND_MAX = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic        wb_en, iss_en;
    logic [4:0]  wb_addr, iss_addr;
    logic [31:0] wb_data;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic        iss_ready_a, iss_ready_b, stall_a, stall_b, wb_err_a, wb_err_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_regfile_scoreboard #(.BYPASS(1)) u_dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .iss_ready(iss_ready_a), .stall(stall_a), .wb_err(wb_err_a)
    );

    mips_regfile_scoreboard #(.BYPASS(0)) u_dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .iss_ready(iss_ready_b), .stall(stall_b), .wb_err(wb_err_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural values and outstanding-write counts.
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_err;
    bit          m_valid = 1'b0;

    function automatic bit m_dec();
        return wb_en && (wb_addr != 0) && (m_cnt[wb_addr] > 0);
    endfunction

    function automatic bit m_ready();
        return (m_cnt[iss_addr] < PEND_MAX) || (m_dec() && (wb_addr == iss_addr));
    endfunction

    function automatic logic [31:0] exp_rd(input int a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && wb_en && (wb_addr == a)) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input int a, input bit byp);
        return (m_cnt[a] != 0) && !(byp && wb_en && (wb_addr == a) && (m_cnt[a] == 1));
    endfunction

    task automatic compare_dut(input string name, input logic [63:0] rdd, input logic [1:0] busy,
                               input logic st, input logic rdy, input logic err, input bit byp);
        bit any_busy = 1'b0;
        for (int p = 0; p < 2; p++) begin
            int a = int'(rd_addr[p*AW +: AW]);
            check_eq($sformatf("%s.rd_data%0d", name, p), rdd[p*32 +: 32], exp_rd(a, byp));
            check_eq($sformatf("%s.rd_busy%0d", name, p), busy[p], exp_busy(a, byp));
            any_busy |= exp_busy(a, byp);
        end
        check_eq({name, ".stall"}, st, any_busy);
        check_eq({name, ".iss_ready"}, rdy, m_ready());
        check_eq({name, ".wb_err"}, err, m_err);
    endtask

    task automatic model_update();
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'h0;
                m_cnt[r]  = 0;
            end
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else begin
            bit dec = m_dec();
            bit acc = iss_en && m_ready() && (iss_addr != 0);
            if (wb_en && (wb_addr != 0)) begin
                if (m_cnt[wb_addr] == 0) m_err = 1'b1;
                m_regs[wb_addr] = wb_data;
            end
            if (dec) m_cnt[wb_addr] = m_cnt[wb_addr] - 1;
            if (acc) m_cnt[iss_addr] = m_cnt[iss_addr] + 1;
        end
    endtask

    task automatic apply(input bit rst, input bit wbe, input int wba, input logic [31:0] wbd,
                         input bit isse, input int issa, input int ra0, input int ra1);
        @(negedge clk);
        reset    = rst;
        wb_en    = wbe;
        wb_addr  = 5'(wba);
        wb_data  = wbd;
        iss_en   = isse;
        iss_addr = 5'(issa);
        rd_addr  = {5'(ra1), 5'(ra0)};
        #1;
        if (m_valid) begin
            compare_dut("byp", rd_data_a, rd_busy_a, stall_a, iss_ready_a, wb_err_a, 1'b1);
            compare_dut("nobyp", rd_data_b, rd_busy_b, stall_b, iss_ready_b, wb_err_b, 1'b0);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
    endtask

    initial begin
        apply(1, 0, 0, 0, 0, 0, 0, 0); advance();

        // T1: reset clears a written register
        apply(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0); advance();
        apply(1, 0, 0, 0, 0, 0, 5, 0); advance();
        apply(0, 0, 0, 0, 0, 0, 5, 0);
        check_eq("t1_rd_r5", rd_data_a[31:0], 32'h0);
        check_eq("t1_stall", stall_a, 1'b0);
        check_eq("t1_wb_err", wb_err_a, 1'b0);
        check_eq("t1_iss_ready", iss_ready_a, 1'b1);
        advance();

        // T2: r0 ignores writes and issues
        apply(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        check_eq("t2_rd_r0_wb", rd_data_a[31:0], 32'h0);
        advance();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t2_rd_r0", rd_data_a[31:0], 32'h0);
        check_eq("t2_busy_r0", rd_busy_a[0], 1'b0);
        check_eq("t2_wb_err", wb_err_a, 1'b0);
        advance();

        // T3: RAW hazard, forwarded vs not
        apply(0, 0, 0, 0, 1, 7, 0, 0); advance();
        apply(0, 0, 0, 0, 0, 0, 7, 0);
        check_eq("t3_busy", rd_busy_a[0], 1'b1);
        check_eq("t3_stall", stall_a, 1'b1);
        advance();
        apply(0, 1, 7, 32'h1234, 0, 0, 7, 0);
        check_eq("t3_fwd_data", rd_data_a[31:0], 32'h1234);
        check_eq("t3_fwd_busy", rd_busy_a[0], 1'b0);
        check_eq("t3_nb_busy", rd_busy_b[0], 1'b1);
        check_eq("t3_nb_old", rd_data_b[31:0], 32'h0);
        advance();
        apply(0, 0, 0, 0, 0, 0, 7, 0);
        check_eq("t3_nb_data", rd_data_b[31:0], 32'h1234);
        check_eq("t3_nb_free", rd_busy_b[0], 1'b0);
        advance();

        // T4: saturation at PEND_MAX
        for (int k = 0; k < PEND_MAX; k++) begin
            apply(0, 0, 0, 0, 1, 3, 3, 0); advance();
        end
        apply(0, 0, 0, 0, 1, 3, 3, 0);
        check_eq("t4_full", iss_ready_a, 1'b0);
        advance();
        apply(0, 1, 3, 32'h1, 1, 3, 3, 0);
        check_eq("t4_wb_frees", iss_ready_a, 1'b1);
        advance();
        apply(0, 0, 0, 0, 1, 3, 3, 0);
        check_eq("t4_still_full", iss_ready_a, 1'b0);
        advance();
        for (int k = 0; k < PEND_MAX; k++) begin
            apply(0, 1, 3, 32'h30 + k, 0, 0, 3, 0); advance();
        end
        apply(0, 0, 0, 0, 0, 0, 3, 0);
        check_eq("t4_drained", rd_busy_a[0], 1'b0);
        check_eq("t4_no_err", wb_err_a, 1'b0);
        check_eq("t4_data", rd_data_a[31:0], 32'h32);
        advance();

        // T5: simultaneous issue and writeback
        apply(0, 0, 0, 0, 1, 9, 0, 0); advance();
        apply(0, 1, 9, 32'h55, 1, 9, 0, 0); advance();
        apply(0, 0, 0, 0, 0, 0, 9, 0);
        check_eq("t5_data", rd_data_a[31:0], 32'h55);
        check_eq("t5_busy", rd_busy_a[0], 1'b1);
        advance();
        apply(0, 1, 9, 32'h56, 0, 0, 0, 0); advance();

        // T6: underflow is sticky until reset
        apply(0, 1, 12, 32'hA, 0, 0, 0, 0);
        check_eq("t6_pre_err", wb_err_a, 1'b0);
        advance();
        apply(0, 0, 0, 0, 0, 0, 12, 0);
        check_eq("t6_data", rd_data_a[31:0], 32'hA);
        check_eq("t6_err", wb_err_a, 1'b1);
        advance();
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0); advance();
        end
        check_eq("t6_err_held", wb_err_a, 1'b1);
        apply(1, 1, 4, 32'h77, 1, 4, 0, 0); advance();
        apply(0, 0, 0, 0, 0, 0, 4, 0);
        check_eq("t6_err_clr", wb_err_a, 1'b0);
        check_eq("t6_rst_wins", rd_busy_a[0], 1'b0);
        advance();

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 2000; n++) begin
            apply($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
